// File: rtl/part_hist_multi.sv
// Multi-channel partial-histogram engine: N_CH packed lanes accumulate into per-channel
// bin counters over a programmable window, then drain counts and per-channel modes.

module part_hist_lane #(
    parameter int SAMPLE_W = 8,
    parameter int BIN_W    = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acc_en,
    input  logic [BIN_W-1:0] acc_bin,
    input  logic             clr_en,
    input  logic [BIN_W-1:0] rd_bin,
    output logic [CNT_W-1:0] rd_cnt,
    output logic             sat_hit
);
    localparam int NB = 1 << BIN_W;

    logic [CNT_W-1:0] cnt [NB];

    assign rd_cnt  = cnt[rd_bin];
    // A hit on an already-full counter is the saturating event; the count holds.
    assign sat_hit = acc_en && (cnt[acc_bin] == {CNT_W{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NB; b++) cnt[b] <= '0;
        end else if (acc_en) begin
            if (!sat_hit) cnt[acc_bin] <= cnt[acc_bin] + CNT_W'(1);
        end else if (clr_en) begin
            cnt[rd_bin] <= '0;
        end
    end
endmodule

module part_hist_multi #(
    parameter int N_CH     = 4,
    parameter int SAMPLE_W = 8,
    parameter int BIN_W    = 4,
    parameter int CNT_W    = 16,
    parameter int MODE_W   = 16
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic                     ap_start,
    output logic                     ap_done,
    output logic                     ap_idle,
    output logic                     ap_ready,
    input  logic [N_CH*SAMPLE_W-1:0] data_in_V,
    input  logic                     input_valid_V,
    output logic                     input_ready,
    input  logic [31:0]              accumulation_V,
    output logic [CNT_W-1:0]         frequency_out_V_V_din,
    input  logic                     frequency_out_V_V_full_n,
    output logic                     frequency_out_V_V_write,
    output logic [MODE_W-1:0]        mode_out_V_V_din,
    input  logic                     mode_out_V_V_full_n,
    output logic                     mode_out_V_V_write,
    output logic [N_CH-1:0]          sat_flags
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN_FREQ, DRAIN_MODE, DONE} state_t;

    state_t                        state;
    logic [31:0]                   win_len;
    logic [31:0]                   win_cnt;
    logic [CH_W-1:0]               ch;
    logic [BIN_W-1:0]              bin;
    logic [CNT_W-1:0]              max_cnt;
    logic [BIN_W-1:0]              argmax;
    logic [N_CH-1:0][CNT_W-1:0]    lane_cnt;
    logic [N_CH-1:0]               sat_hit;
    logic [CNT_W-1:0]              cur_cnt;
    logic                          accept;
    logic                          freq_wr;
    logic                          mode_wr;
    logic                          unused_low_bits;

    assign accept  = input_valid_V && input_ready;
    assign freq_wr = (state == DRAIN_FREQ) && frequency_out_V_V_full_n;
    assign mode_wr = (state == DRAIN_MODE) && mode_out_V_V_full_n;
    assign cur_cnt = lane_cnt[ch];

    assign frequency_out_V_V_din   = (state == DRAIN_FREQ) ? cur_cnt : '0;
    assign frequency_out_V_V_write = freq_wr;
    assign mode_out_V_V_din        = (state == DRAIN_MODE) ? MODE_W'(argmax) : '0;
    assign mode_out_V_V_write      = mode_wr;

    // Only the top BIN_W bits of each lane select a bin.
    assign unused_low_bits = ^data_in_V;

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        part_hist_lane #(
            .SAMPLE_W (SAMPLE_W),
            .BIN_W    (BIN_W),
            .CNT_W    (CNT_W)
        ) u_lane (
            .clk     (ap_clk),
            .rst     (ap_rst),
            .acc_en  (accept),
            .acc_bin (data_in_V[i*SAMPLE_W + SAMPLE_W - 1 -: BIN_W]),
            .clr_en  (freq_wr && (ch == CH_W'(i))),
            .rd_bin  (bin),
            .rd_cnt  (lane_cnt[i]),
            .sat_hit (sat_hit[i])
        );
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state       <= IDLE;
            win_len     <= '0;
            win_cnt     <= '0;
            ch          <= '0;
            bin         <= '0;
            max_cnt     <= '0;
            argmax      <= '0;
            sat_flags   <= '0;
            ap_idle     <= 1'b1;
            ap_done     <= 1'b0;
            ap_ready    <= 1'b0;
            input_ready <= 1'b0;
        end else begin
            ap_done  <= 1'b0;
            ap_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        state       <= ACCUM;
                        ap_idle     <= 1'b0;
                        input_ready <= 1'b1;
                        win_len     <= (accumulation_V == 32'd0) ? 32'd1 : accumulation_V;
                        win_cnt     <= '0;
                        sat_flags   <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        sat_flags <= sat_flags | sat_hit;
                        win_cnt   <= win_cnt + 32'd1;
                        if (win_cnt + 32'd1 == win_len) begin
                            state       <= DRAIN_FREQ;
                            input_ready <= 1'b0;
                            ch          <= '0;
                            bin         <= '0;
                            max_cnt     <= '0;
                            argmax      <= '0;
                        end
                    end
                end
                DRAIN_FREQ: begin
                    if (freq_wr) begin
                        // Strict compare keeps the lowest bin on ties.
                        if (cur_cnt > max_cnt) begin
                            max_cnt <= cur_cnt;
                            argmax  <= bin;
                        end
                        bin <= bin + BIN_W'(1);
                        if (bin == {BIN_W{1'b1}}) state <= DRAIN_MODE;
                    end
                end
                DRAIN_MODE: begin
                    if (mode_wr) begin
                        if (ch == CH_W'(N_CH - 1)) begin
                            state    <= DONE;
                            ap_done  <= 1'b1;
                            ap_ready <= 1'b1;
                        end else begin
                            ch      <= ch + CH_W'(1);
                            bin     <= '0;
                            max_cnt <= '0;
                            argmax  <= '0;
                            state   <= DRAIN_FREQ;
                        end
                    end
                end
                DONE: begin
                    if (ap_start) begin
                        state       <= ACCUM;
                        input_ready <= 1'b1;
                        win_len     <= (accumulation_V == 32'd0) ? 32'd1 : accumulation_V;
                        win_cnt     <= '0;
                        sat_flags   <= '0;
                    end else begin
                        state   <= IDLE;
                        ap_idle <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    ap_idle     <= 1'b1;
                    input_ready <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_part_hist_multi.sv
// Directed bench for part_hist_multi: a default instance plus a CNT_W=4 instance sharing
// all inputs, with write strobes captured into queues and checked against hand-built tables.

module tb_part_hist_multi;
    logic        clk = 0, rst = 1, start = 0, valid = 0, ffull_n = 1, mfull_n = 1;
    logic [31:0] data = 0, acc = 0;

    logic        done, idle, apready, in_ready, fwr, mwr;
    logic [15:0] fdin, mdin;
    logic [3:0]  sat;
    logic        s_done, s_idle, s_apready, s_in_ready, s_fwr, s_mwr;
    logic [3:0]  s_fdin;
    logic [15:0] s_mdin;
    logic [3:0]  s_sat;

    int checks = 0, errors = 0;
    int cyc = 0, last_acc = 0;
    int both_err = 0, bp_err = 0, rdy_err = 0, dr_err = 0;
    int fq[$], mq[$], sfq[$], smq[$], dq[$];
    int exp_f[64], exp_m[4], sexp_f[64], sexp_m[4];

    part_hist_multi u_dut (
        .ap_clk(clk), .ap_rst(rst), .ap_start(start), .ap_done(done), .ap_idle(idle),
        .ap_ready(apready), .data_in_V(data), .input_valid_V(valid), .input_ready(in_ready),
        .accumulation_V(acc), .frequency_out_V_V_din(fdin),
        .frequency_out_V_V_full_n(ffull_n), .frequency_out_V_V_write(fwr),
        .mode_out_V_V_din(mdin), .mode_out_V_V_full_n(mfull_n), .mode_out_V_V_write(mwr),
        .sat_flags(sat)
    );

    part_hist_multi #(.CNT_W(4)) u_sat (
        .ap_clk(clk), .ap_rst(rst), .ap_start(start), .ap_done(s_done), .ap_idle(s_idle),
        .ap_ready(s_apready), .data_in_V(data), .input_valid_V(valid), .input_ready(s_in_ready),
        .accumulation_V(acc), .frequency_out_V_V_din(s_fdin),
        .frequency_out_V_V_full_n(ffull_n), .frequency_out_V_V_write(s_fwr),
        .mode_out_V_V_din(s_mdin), .mode_out_V_V_full_n(mfull_n), .mode_out_V_V_write(s_mwr),
        .sat_flags(s_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fwr) fq.push_back(int'(fdin));
        if (mwr) mq.push_back(int'(mdin));
        if (s_fwr) sfq.push_back(int'(s_fdin));
        if (s_mwr) smq.push_back(int'(s_mdin));
        if (done) dq.push_back(cyc);
        if (fwr && mwr) both_err++;
        if ((fwr && !ffull_n) || (mwr && !mfull_n)) bp_err++;
        if ((fwr || mwr) && in_ready) rdy_err++;
        if (done !== apready) dr_err++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_all();
        fq.delete(); mq.delete(); sfq.delete(); smq.delete(); dq.delete();
        for (int k = 0; k < 64; k++) begin exp_f[k] = 0; sexp_f[k] = 0; end
        for (int c = 0; c < 4; c++) begin exp_m[c] = 0; sexp_m[c] = 0; end
    endtask

    task automatic check_win(input string tag, input int base, input bit s);
        int o;
        for (int k = 0; k < 64; k++) begin
            if (s) begin
                o = (sfq.size() > base + k) ? sfq[base + k] : -1;
                chk($sformatf("%s_f%0d", tag, k), o, sexp_f[k]);
            end else begin
                o = (fq.size() > base + k) ? fq[base + k] : -1;
                chk($sformatf("%s_f%0d", tag, k), o, exp_f[k]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (s) begin
                o = (smq.size() > base / 16 + c) ? smq[base / 16 + c] : -1;
                chk($sformatf("%s_m%0d", tag, c), o, sexp_m[c]);
            end else begin
                o = (mq.size() > base / 16 + c) ? mq[base / 16 + c] : -1;
                chk($sformatf("%s_m%0d", tag, c), o, exp_m[c]);
            end
        end
    endtask

    task automatic start_window(input logic [31:0] a);
        start = 1; acc = a;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic feed(input logic [31:0] d);
        bit ok = 0;
        data = d; valid = 1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; last_acc = cyc; end
            @(posedge clk); #1;
        end
        valid = 0;
        chk("feed_accept", ok, 1);
    endtask

    task automatic wait_done(input string tag, input int n);
        int t = 0;
        while (dq.size() < n && t < 400) begin @(posedge clk); #1; t++; end
        chk(tag, dq.size() >= n, 1);
    endtask

    task automatic wait_fq(input string tag, input int n);
        int t = 0;
        while (fq.size() < n && t < 400) begin @(posedge clk); #1; t++; end
        chk(tag, fq.size() >= n, 1);
    endtask

    initial begin
        int n0, m0;
        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_idle", idle, 1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_fwr", fwr, 0);
        chk("rst_mwr", mwr, 0);
        chk("rst_fdin", fdin, 0);
        chk("rst_mdin", mdin, 0);
        chk("rst_sat", sat, 0);
        @(posedge clk); #1;

        // Case 1: three all-zero words
        clr_all();
        for (int c = 0; c < 4; c++) exp_f[16 * c] = 3;
        start_window(3);
        repeat (3) feed(32'h0);
        wait_done("c1_done", 1);
        repeat (3) @(posedge clk); #1;
        chk("c1_nwords", fq.size(), 64);
        chk("c1_nmodes", mq.size(), 4);
        chk("c1_ndone", dq.size(), 1);
        chk("c1_latency", dq[0] - last_acc, 69);
        chk("c1_sat", sat, 0);
        chk("c1_idle", idle, 1);
        check_win("c1", 0, 0);

        // Case 2: tie between bins 5 and 2 on ch0 resolves to the lower bin
        clr_all();
        exp_f[5] = 1; exp_f[2] = 1; exp_m[0] = 2;
        for (int c = 1; c < 4; c++) exp_f[16 * c] = 2;
        start_window(2);
        feed(32'h0000_0050);
        feed(32'h0000_0020);
        wait_done("c2_done", 1);
        check_win("c2", 0, 0);

        // Case 3: frequency backpressure for 10 cycles at word 20
        clr_all();
        for (int c = 0; c < 4; c++) exp_f[16 * c] = 3;
        start_window(3);
        repeat (3) feed(32'h0);
        wait_fq("c3_reach20", 20);
        ffull_n = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("c3_stall_hold", fq.size(), 20);
        ffull_n = 1;
        wait_done("c3_done", 1);
        repeat (2) @(posedge clk); #1;
        chk("c3_nwords", fq.size(), 64);
        chk("c3_latency", dq[0] - last_acc, 79);
        check_win("c3", 0, 0);

        // Case 4: saturation on the CNT_W=4 instance, then a clean follow-up window
        clr_all();
        for (int c = 0; c < 4; c++) begin
            exp_f[16 * c + 15] = 20; exp_m[c] = 15;
            sexp_f[16 * c + 15] = 15; sexp_m[c] = 15;
        end
        start_window(20);
        repeat (20) feed(32'hF0F0_F0F0);
        wait_done("c4_done", 1);
        chk("c4_sat_small", s_sat, 4'hF);
        chk("c4_sat_wide", sat, 4'h0);
        check_win("c4s", 0, 1);
        check_win("c4w", 0, 0);
        clr_all();
        for (int c = 0; c < 4; c++) begin exp_f[16 * c] = 1; sexp_f[16 * c] = 1; end
        start_window(1);
        @(negedge clk);
        chk("c4_sat_cleared", s_sat, 0);
        @(posedge clk); #1;
        feed(32'h0);
        wait_done("c4b_done", 1);
        check_win("c4b", 0, 1);

        // Case 5: reset mid-drain, then a rerun with no residue
        clr_all();
        start_window(1);
        feed(32'h1234_5678);
        wait_fq("c5_reach30", 30);
        rst = 1;
        @(posedge clk); #1;
        n0 = fq.size(); m0 = mq.size();
        @(posedge clk); #1;
        rst = 0;
        repeat (20) @(posedge clk); #1;
        chk("c5_no_fwr", fq.size(), n0);
        chk("c5_no_mwr", mq.size(), m0);
        chk("c5_idle", idle, 1);
        chk("c5_no_done", dq.size(), 0);
        clr_all();
        for (int c = 0; c < 4; c++) begin exp_f[16 * c + 1] = 1; exp_m[c] = 1; end
        start_window(1);
        feed(32'h1111_1111);
        wait_done("c5_done", 1);
        check_win("c5", 0, 0);

        // Case 6: start and valid held high, accumulation_V=0 means one word per window
        clr_all();
        for (int c = 0; c < 4; c++) begin exp_f[16 * c + 1] = 1; exp_m[c] = 1; end
        acc = 0; data = 32'h1111_1111; valid = 1; start = 1;
        wait_done("c6_done1", 1);
        repeat (5) @(posedge clk); #1;
        start = 0;
        wait_done("c6_done2", 2);
        valid = 0;
        repeat (3) @(posedge clk); #1;
        chk("c6_nwords", fq.size(), 128);
        chk("c6_ndone", dq.size(), 2);
        chk("c6_back2back", dq[1] - dq[0], 70);
        chk("c6_idle", idle, 1);
        check_win("c6a", 0, 0);
        check_win("c6b", 64, 0);

        chk("never_both_writes", both_err, 0);
        chk("no_write_when_full", bp_err, 0);
        chk("ready_low_in_drain", rdy_err, 0);
        chk("ready_eq_done", dr_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
